// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA test-pattern sequencer.
package vga_pkg;

  localparam int PAT_W = 2;

  typedef enum logic [PAT_W-1:0] {
    PAT_GREY  = 2'd0,
    PAT_RED   = 2'd1,
    PAT_WHITE = 2'd2,
    PAT_BARS  = 2'd3
  } pat_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    APPLY   = 2'd2
  } state_e;

  // Patterns advance cyclically; 3 wraps back to 0.
  function automatic logic [PAT_W-1:0] pat_next(input logic [PAT_W-1:0] p);
    return p + PAT_W'(1);
  endfunction

endpackage

// File: rtl/vga_debounce.sv
// Button conditioner: 2-flop synchronizer, stability counter, one-cycle press pulse.
module vga_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 17
) (
  input  logic clock,
  input  logic reset_n,
  input  logic btn,
  output logic press
);

  logic [1:0]       sync;
  logic             level;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sync  <= 2'b00;
      level <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync  <= {sync[0], btn};
      press <= 1'b0;
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        // Level accepted; a rising acceptance is the press event.
        level <= sync[1];
        cnt   <= '0;
        press <= sync[1];
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/vga_pattern_ctrl.sv
// Pattern sequencer: collects button, auto-cycle and bus load requests and
// applies them only at a vsync boundary so a frame never tears.
//   state   | meaning
//   IDLE    | no request outstanding
//   PENDING | request latched, waiting for the next frame_tick
//   APPLY   | one cycle: update patten, pulse pattern_changed, clear flags
module vga_pattern_ctrl
  import vga_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int AUTO_FRAMES     = 120,
  parameter int CNT_W           = 17
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             sel_btn,
  input  logic             vs_n,
  input  logic             auto_en,
  input  logic             load_en,
  input  logic [PAT_W-1:0] load_pat,
  output logic [PAT_W-1:0] patten,
  output logic             pattern_changed,
  output logic             pending
);

  localparam int FC_W = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;

  logic             press;
  logic             vs_d;
  logic             frame_tick;
  logic [FC_W-1:0]  frame_cnt;
  logic             auto_hit;
  logic             load_flag;
  logic             inc_flag;
  logic [PAT_W-1:0] load_val;
  state_e           state;

  vga_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_debounce (
    .clock   (clock),
    .reset_n (reset_n),
    .btn     (sel_btn),
    .press   (press)
  );

  assign frame_tick = vs_d & ~vs_n;
  assign auto_hit   = frame_tick & auto_en & (frame_cnt == FC_W'(AUTO_FRAMES - 1));
  assign pending    = (state != IDLE) | load_flag | inc_flag;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      vs_d      <= 1'b0;
      frame_cnt <= '0;
    end else begin
      vs_d <= vs_n;
      if (!auto_en || press) begin
        frame_cnt <= '0;
      end else if (frame_tick) begin
        frame_cnt <= auto_hit ? '0 : frame_cnt + FC_W'(1);
      end
    end
  end

  // Clear-on-apply comes first so a request landing in the APPLY cycle survives.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      load_flag <= 1'b0;
      inc_flag  <= 1'b0;
      load_val  <= '0;
    end else begin
      if (state == APPLY) begin
        load_flag <= 1'b0;
        inc_flag  <= 1'b0;
      end
      if (load_en) begin
        load_flag <= 1'b1;
        load_val  <= load_pat;
      end
      if (press || auto_hit) begin
        inc_flag <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state           <= IDLE;
      patten          <= PAT_GREY;
      pattern_changed <= 1'b0;
    end else begin
      pattern_changed <= 1'b0;
      case (state)
        IDLE: begin
          if (load_flag || inc_flag) state <= PENDING;
        end
        PENDING: begin
          if (frame_tick) state <= APPLY;
        end
        APPLY: begin
          patten          <= load_flag ? load_val : pat_next(patten);
          pattern_changed <= 1'b1;
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_pattern_ctrl.sv
// Scoreboard bench for vga_pattern_ctrl with short debounce and auto periods.
module tb_vga_pattern_ctrl;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       sel_btn;
  logic       vs_n;
  logic       auto_en;
  logic       load_en;
  logic [1:0] load_pat;
  logic [1:0] patten;
  logic       pattern_changed;
  logic       pending;

  int         vcnt;
  int         cyc = 0;
  int         last_tick = -100;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         n_pulse = 0;
  logic       vs_prev = 1'b0;
  logic [1:0] exp_q[$];
  int         pulse_cyc[$];
  logic [1:0] exp_v;

  vga_pattern_ctrl #(
    .DEBOUNCE_CYCLES (4),
    .AUTO_FRAMES     (3),
    .CNT_W           (3)
  ) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .sel_btn         (sel_btn),
    .vs_n            (vs_n),
    .auto_en         (auto_en),
    .load_en         (load_en),
    .load_pat        (load_pat),
    .patten          (patten),
    .pattern_changed (pattern_changed),
    .pending         (pending)
  );

  always #5 clock = ~clock;

  // vsync: period 100 clocks, low for the first 4
  initial begin
    vcnt = 99;
    vs_n = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      vcnt = (vcnt == 99) ? 0 : vcnt + 1;
      vs_n = (vcnt < 4) ? 1'b0 : 1'b1;
    end
  end

  always @(posedge clock) vs_prev <= reset_n ? vs_n : 1'b0;

  always @(negedge clock) begin
    cyc++;
    if (vs_prev && !vs_n) last_tick = cyc;
    if (pattern_changed === 1'b1) begin
      n_pulse++;
      pulse_cyc.push_back(cyc);
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_change: patten=%0d required no change", patten);
      end else begin
        exp_v = exp_q.pop_front();
        if (patten !== exp_v) begin
          n_bad++;
          $display("FAIL pattern_value: patten=%0d required %0d", patten, exp_v);
        end
      end
      n_cmp++;
      if (cyc != last_tick + 2) begin
        n_bad++;
        $display("FAIL apply_latency: %0d cycles after tick, required 2", cyc - last_tick);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic wait_vcnt(input int v);
    do step(); while (vcnt != v);
  endtask

  task automatic press_btn();
    sel_btn = 1'b1;
    repeat (10) step();
    sel_btn = 1'b0;
    repeat (10) step();
  endtask

  task automatic load(input logic [1:0] p);
    load_pat = p;
    load_en  = 1'b1;
    step();
    load_en  = 1'b0;
  endtask

  task automatic drain(input int budget, output bit timed_out);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      step();
      k++;
    end
    timed_out = (exp_q.size() != 0);
    exp_q.delete();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; sel_btn = 1'b1; auto_en = 1'b0; load_en = 1'b0; load_pat = 2'd0;
    repeat (3) step();
    n_cmp++;
    if (patten !== 2'd0) begin n_bad++; $display("FAIL reset_patten: got %0d required 0", patten); end
    n_cmp++;
    if (pending !== 1'b0) begin n_bad++; $display("FAIL reset_pending: got %b required 0", pending); end
    n_cmp++;
    if (pattern_changed !== 1'b0) begin n_bad++; $display("FAIL reset_pulse: got %b required 0", pattern_changed); end
    sel_btn = 1'b0;
    repeat (2) step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_bounce();
    bit to;
    int p0;
    wait_vcnt(10);
    p0 = n_pulse;
    exp_q.push_back(2'd1);
    for (int i = 0; i < 10; i++) begin
      sel_btn = ~sel_btn;
      step(); step();
    end
    sel_btn = 1'b0;
    step();
    n_cmp++;
    if (pending !== 1'b0) begin n_bad++; $display("FAIL bounce_rejected: pending=%b required 0", pending); end
    sel_btn = 1'b1;
    repeat (20) step();
    n_cmp++;
    if (pending !== 1'b1) begin n_bad++; $display("FAIL bounce_accepted: pending=%b required 1", pending); end
    sel_btn = 1'b0;
    repeat (20) step();
    drain(300, to);
    n_cmp++;
    if (to) begin n_bad++; $display("FAIL bounce_timeout: no change seen, required change to 1"); end
    n_cmp++;
    if (patten !== 2'd1) begin n_bad++; $display("FAIL bounce_patten: got %0d required 1", patten); end
    repeat (150) step();
    n_cmp++;
    if (n_pulse - p0 != 1) begin n_bad++; $display("FAIL bounce_pulses: got %0d required 1", n_pulse - p0); end
  endtask

  task automatic test_merge_wrap();
    bit to;
    int p0;
    wait_vcnt(10);
    exp_q.push_back(2'd3);
    load(2'd3);
    drain(300, to);
    n_cmp++;
    if (patten !== 2'd3) begin n_bad++; $display("FAIL merge_setup: got %0d required 3", patten); end
    wait_vcnt(10);
    p0 = n_pulse;
    exp_q.push_back(2'd0);
    repeat (3) press_btn();
    drain(300, to);
    n_cmp++;
    if (to || patten !== 2'd0) begin n_bad++; $display("FAIL merge_wrap: got %0d required 0", patten); end
    repeat (150) step();
    n_cmp++;
    if (n_pulse - p0 != 1) begin n_bad++; $display("FAIL merge_pulses: got %0d required 1", n_pulse - p0); end
  endtask

  task automatic test_priority();
    bit to;
    int p0;
    wait_vcnt(10);
    p0 = n_pulse;
    exp_q.push_back(2'd2);
    press_btn();
    load(2'd2);
    drain(300, to);
    n_cmp++;
    if (to || patten !== 2'd2) begin n_bad++; $display("FAIL priority_load: got %0d required 2", patten); end
    repeat (150) step();
    n_cmp++;
    if (n_pulse - p0 != 1) begin n_bad++; $display("FAIL priority_pulses: got %0d required 1", n_pulse - p0); end
  endtask

  task automatic test_back_to_back();
    bit to;
    int p0;
    wait_vcnt(10);
    p0 = n_pulse;
    exp_q.push_back(2'd2);
    load(2'd2);
    drain(300, to);
    n_cmp++;
    if (to || n_pulse - p0 != 1) begin n_bad++; $display("FAIL load_same_pulse: got %0d pulses required 1", n_pulse - p0); end
    wait_vcnt(10);
    exp_q.push_back(2'd3);
    load(2'd1);
    step();
    load(2'd3);
    drain(300, to);
    n_cmp++;
    if (to || patten !== 2'd3) begin n_bad++; $display("FAIL load_overwrite: got %0d required 3", patten); end
    // second load issued during APPLY must carry to the following frame
    wait_vcnt(10);
    exp_q.push_back(2'd1);
    exp_q.push_back(2'd2);
    load(2'd1);
    wait_vcnt(1);
    load(2'd2);
    drain(400, to);
    n_cmp++;
    if (to || patten !== 2'd2) begin n_bad++; $display("FAIL apply_carry: got %0d required 2", patten); end
    n_cmp++;
    if (pulse_cyc[$] - pulse_cyc[$-1] != 100) begin
      n_bad++;
      $display("FAIL apply_carry_gap: got %0d cycles required 100", pulse_cyc[$] - pulse_cyc[$-1]);
    end
  endtask

  task automatic test_auto();
    bit to;
    int p1;
    int n;
    reset_n = 1'b0;
    repeat (3) step();
    reset_n = 1'b1;
    wait_vcnt(10);
    exp_q.push_back(2'd1); exp_q.push_back(2'd2);
    exp_q.push_back(2'd3); exp_q.push_back(2'd0);
    auto_en = 1'b1;
    drain(1500, to);
    n_cmp++;
    if (to || patten !== 2'd0) begin n_bad++; $display("FAIL auto_sequence: got %0d required 0", patten); end
    n = pulse_cyc.size();
    for (int i = n - 3; i < n; i++) begin
      n_cmp++;
      if (pulse_cyc[i] - pulse_cyc[i-1] != 300) begin
        n_bad++;
        $display("FAIL auto_period: got %0d cycles required 300", pulse_cyc[i] - pulse_cyc[i-1]);
      end
    end
    wait_vcnt(50);
    auto_en = 1'b0;
    p1 = n_pulse;
    repeat (1000) step();
    n_cmp++;
    if (n_pulse != p1 || patten !== 2'd0) begin
      n_bad++;
      $display("FAIL auto_disable: got %0d pulses patten %0d required 0 pulses patten 0", n_pulse - p1, patten);
    end
  endtask

  task automatic test_reset_pending();
    bit to;
    int p0;
    wait_vcnt(10);
    exp_q.push_back(2'd2);
    load(2'd2);
    drain(300, to);
    n_cmp++;
    if (to || patten !== 2'd2) begin n_bad++; $display("FAIL rstpend_setup: got %0d required 2", patten); end
    wait_vcnt(10);
    press_btn();
    n_cmp++;
    if (pending !== 1'b1) begin n_bad++; $display("FAIL rstpend_pending: got %b required 1", pending); end
    reset_n = 1'b0;
    repeat (3) step();
    reset_n = 1'b1;
    n_cmp++;
    if (pending !== 1'b0 || patten !== 2'd0) begin
      n_bad++;
      $display("FAIL rstpend_cleared: pending=%b patten=%0d required 0 and 0", pending, patten);
    end
    p0 = n_pulse;
    repeat (150) step();
    n_cmp++;
    if (n_pulse != p0 || patten !== 2'd0) begin
      n_bad++;
      $display("FAIL rstpend_discard: got %0d pulses patten %0d required 0 pulses patten 0", n_pulse - p0, patten);
    end
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_merge_wrap();
    test_priority();
    test_back_to_back();
    test_auto();
    test_reset_pending();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
